// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes and counter sizing.
package serial_adder_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit counter must hold values 0..width without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single 1-bit full-adder cell used as the per-bit step of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: A + B + cin, one bit per clock, LSB first,
// with valid/ready handshakes on operands and result.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  import serial_adder_pkg::*;

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [ST_W-1:0]  state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q,   busy_d;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign start_ready = (state_q == ST_IDLE) && !rst;

  // Next-state and datapath; sum/cout are captured only on the final RUN edge.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid && start_ready) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_co;
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          sum_d   = sum_sr_d;
          cout_d  = fa_co;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule
